// File: rtl/nubus_master_watchdog_if.sv
// Handshake bundle between the NuBus master path and its transaction watchdog.
// The master modport is the watchdog's view; slave is the master controller's view.
interface nubus_master_watchdog_if;
    logic       mst_start;
    logic       mst_abort;
    logic       nub_ackn;
    logic [1:0] nub_tmn;
    logic       mst_busy;
    logic       mst_retry;
    logic       mst_done;
    logic       mst_timeout;
    logic       mst_giveup;
    logic [7:0] retry_count;

    modport master (
        input  mst_start,
        input  mst_abort,
        input  nub_ackn,
        input  nub_tmn,
        output mst_busy,
        output mst_retry,
        output mst_done,
        output mst_timeout,
        output mst_giveup,
        output retry_count
    );

    modport slave (
        output mst_start,
        output mst_abort,
        output nub_ackn,
        output nub_tmn,
        input  mst_busy,
        input  mst_retry,
        input  mst_done,
        input  mst_timeout,
        input  mst_giveup,
        input  retry_count
    );
endinterface

// File: rtl/nubus_master_watchdog.sv
// NuBus master transaction watchdog: times START-to-ACK and reissues on TRY_AGAIN_LATER.
// Define NUBUS_RETRY_EN to build the retry/backoff path; otherwise TRY_AGAIN_LATER gives up.
module nubus_master_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETRY_MAX      = 8,
    parameter int unsigned BACKOFF_CYCLES = 4
) (
    input logic                     nub_clkn,
    input logic                     nub_reset,
    nubus_master_watchdog_if.master bus
);

    localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;
    localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b01;
    localparam logic [1:0] TMN_ERROR           = 2'b10;
    localparam logic [1:0] TMN_COMPLETE        = 2'b11;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || RETRY_MAX < 1 || RETRY_MAX > 255 ||
        BACKOFF_CYCLES < 1 || BACKOFF_CYCLES > 255) begin : g_param_check
        $error("nubus_master_watchdog: parameter out of legal range");
    end

`ifdef NUBUS_RETRY_EN
    typedef enum logic [1:0] {StIdle, StWaitAck, StBackoff, StRetry} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWaitAck} state_e;
`endif

    state_e      state_q;
    logic [15:0] tcnt_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic        giveup_q;

`ifdef NUBUS_RETRY_EN
    localparam logic [7:0]  RETRY_LAST   = 8'(RETRY_MAX);
    localparam logic [11:0] BACKOFF_BASE = 12'(BACKOFF_CYCLES);

    logic [7:0]  rcnt_q;
    logic [11:0] bcnt_q;
    logic        retry_q;
    logic [2:0]  bshift;
    logic [11:0] backoff_len;

    // rcnt_q is the pre-increment count, i.e. (new retry_count - 1); shift saturates at 4.
    assign bshift      = (rcnt_q >= 8'd4) ? 3'd4 : rcnt_q[2:0];
    assign backoff_len = BACKOFF_BASE << bshift;
`endif

    always_ff @(negedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q   <= StIdle;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            giveup_q  <= 1'b0;
`ifdef NUBUS_RETRY_EN
            rcnt_q    <= '0;
            bcnt_q    <= '0;
            retry_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            giveup_q  <= 1'b0;
`ifdef NUBUS_RETRY_EN
            retry_q   <= 1'b0;
`endif
            // Abort outranks ACK and timeout; retry_count is left for the master to inspect.
            if (state_q != StIdle && bus.mst_abort) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tcnt_q <= '0;
                        if (bus.mst_start) begin
                            state_q <= StWaitAck;
                            busy_q  <= 1'b1;
`ifdef NUBUS_RETRY_EN
                            rcnt_q  <= '0;
`endif
                        end
                    end
                    StWaitAck: begin
                        if (!bus.nub_ackn) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            unique case (bus.nub_tmn)
                                TMN_COMPLETE, TMN_ERROR: done_q <= 1'b1;
                                TMN_TIMEOUT_ERROR: begin
                                    done_q    <= 1'b1;
                                    timeout_q <= 1'b1;
                                end
                                TMN_TRY_AGAIN_LATER: begin
`ifdef NUBUS_RETRY_EN
                                    if (rcnt_q < RETRY_LAST) begin
                                        state_q <= StBackoff;
                                        busy_q  <= 1'b1;
                                        rcnt_q  <= rcnt_q + 8'd1;
                                        bcnt_q  <= backoff_len;
                                    end else begin
                                        done_q   <= 1'b1;
                                        giveup_q <= 1'b1;
                                    end
`else
                                    done_q   <= 1'b1;
                                    giveup_q <= 1'b1;
`endif
                                end
                                default: done_q <= 1'b1;
                            endcase
                        end else if (tcnt_q == TIMEOUT_LAST) begin
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                        end else begin
                            tcnt_q <= tcnt_q + 16'd1;
                        end
                    end
`ifdef NUBUS_RETRY_EN
                    StBackoff: begin
                        if (bcnt_q <= 12'd1) begin
                            state_q <= StRetry;
                            retry_q <= 1'b1;
                            bcnt_q  <= '0;
                        end else begin
                            bcnt_q <= bcnt_q - 12'd1;
                        end
                    end
                    StRetry: begin
                        state_q <= StWaitAck;
                        tcnt_q  <= '0;
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mst_busy    = busy_q;
    assign bus.mst_done    = done_q;
    assign bus.mst_timeout = timeout_q;
    assign bus.mst_giveup  = giveup_q;
`ifdef NUBUS_RETRY_EN
    assign bus.mst_retry   = retry_q;
    assign bus.retry_count = rcnt_q;
`else
    assign bus.mst_retry   = 1'b0;
    assign bus.retry_count = '0;
`endif

endmodule

// File: tb/tb_nubus_master_watchdog.sv
// Directed self-checking bench for nubus_master_watchdog at default parameters.
// Inputs change and outputs are sampled 1 time unit after each falling edge of nub_clkn.
module tb_nubus_master_watchdog;

    localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;
    localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b01;
    localparam logic [1:0] TMN_ERROR           = 2'b10;
    localparam logic [1:0] TMN_COMPLETE        = 2'b11;

    logic nub_clkn = 1'b1;
    logic nub_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   first_to, n_to, n_done, gap;
    logic seen;
    int   exp_gap [8] = '{4, 8, 16, 32, 64, 64, 64, 64};

    nubus_master_watchdog_if bus ();

    nubus_master_watchdog dut (
        .nub_clkn  (nub_clkn),
        .nub_reset (nub_reset),
        .bus       (bus)
    );

    always #5 nub_clkn = ~nub_clkn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge nub_clkn);
        #1;
    endtask

    task automatic start_txn();
        bus.mst_start = 1'b1;
        tick();
        bus.mst_start = 1'b0;
    endtask

    task automatic ack(input logic [1:0] code);
        bus.nub_ackn = 1'b0;
        bus.nub_tmn  = code;
        tick();
        bus.nub_ackn = 1'b1;
        bus.nub_tmn  = TMN_COMPLETE;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        bus.mst_start = 1'b0;
        bus.mst_abort = 1'b0;
        bus.nub_ackn  = 1'b1;
        bus.nub_tmn   = TMN_COMPLETE;
        nub_reset     = 1'b1;
        repeat (3) tick();
        nub_reset = 1'b0;
        tick();
        check("rst_busy", bus.mst_busy, 0);
        check("rst_retry", bus.mst_retry, 0);
        check("rst_done", bus.mst_done, 0);
        check("rst_timeout", bus.mst_timeout, 0);
        check("rst_giveup", bus.mst_giveup, 0);
        check("rst_retry_count", bus.retry_count, 0);

        // Normal completion: ACK sampled on the 5th edge after START.
        start_txn();
        check("start_busy", bus.mst_busy, 1);
        repeat (4) tick();
        check("pre_ack_done", bus.mst_done, 0);
        ack(TMN_COMPLETE);
        check("ok_done", bus.mst_done, 1);
        check("ok_timeout", bus.mst_timeout, 0);
        check("ok_giveup", bus.mst_giveup, 0);
        check("ok_busy", bus.mst_busy, 0);

        // Back-to-back START in the first IDLE cycle after done.
        start_txn();
        check("b2b_busy", bus.mst_busy, 1);
        check("b2b_done_single", bus.mst_done, 0);
        ack(TMN_ERROR);
        check("err_done", bus.mst_done, 1);
        check("err_busy", bus.mst_busy, 0);

        // Local timeout with no ACK.
        start_txn();
        first_to = 0;
        n_to     = 0;
        n_done   = 0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (bus.mst_timeout) begin
                n_to++;
                if (first_to == 0) first_to = k;
            end
            if (bus.mst_done) n_done++;
        end
        check("to_cycle", first_to, 255);
        check("to_pulses", n_to, 1);
        check("to_done_pulses", n_done, 1);
        check("to_busy", bus.mst_busy, 0);

        // ACK in cycle 254 coincides with expiry; ACK wins.
        start_txn();
        n_to = 0;
        for (int k = 1; k <= 254; k++) begin
            tick();
            if (bus.mst_timeout) n_to++;
        end
        ack(TMN_COMPLETE);
        check("coin_done", bus.mst_done, 1);
        check("coin_timeout", bus.mst_timeout, 0);
        check("coin_early_to", n_to, 0);

        // Slave-reported bus timeout behaves like a local timeout.
        start_txn();
        tick();
        ack(TMN_TIMEOUT_ERROR);
        check("tmerr_timeout", bus.mst_timeout, 1);
        check("tmerr_done", bus.mst_done, 1);
        check("tmerr_giveup", bus.mst_giveup, 0);

        // Abort outranks a same-cycle ACK.
        start_txn();
        bus.mst_abort = 1'b1;
        ack(TMN_COMPLETE);
        bus.mst_abort = 1'b0;
        check("abort_ack_done", bus.mst_done, 0);
        check("abort_ack_busy", bus.mst_busy, 0);

`ifdef NUBUS_RETRY_EN
        // Retry ladder.
        start_txn();
        tick();
        for (int a = 0; a < 8; a++) begin
            ack(TMN_TRY_AGAIN_LATER);
            check("ladder_count", bus.retry_count, a + 1);
            check("ladder_busy", bus.mst_busy, 1);
            gap  = 0;
            seen = 1'b0;
            for (int n = 1; n <= 200 && !seen; n++) begin
                tick();
                if (bus.mst_retry) begin
                    gap  = n;
                    seen = 1'b1;
                end
            end
            check("ladder_gap", gap, exp_gap[a]);
            tick();
            check("ladder_retry_single", bus.mst_retry, 0);
        end
        ack(TMN_TRY_AGAIN_LATER);
        check("ladder_giveup", bus.mst_giveup, 1);
        check("ladder_done", bus.mst_done, 1);
        check("ladder_final_count", bus.retry_count, 8);
        check("ladder_busy_end", bus.mst_busy, 0);

        // Abort while in BACKOFF.
        start_txn();
        tick();
        ack(TMN_TRY_AGAIN_LATER);
        tick();
        bus.mst_abort = 1'b1;
        tick();
        bus.mst_abort = 1'b0;
        check("bo_abort_busy", bus.mst_busy, 0);
        check("bo_abort_done", bus.mst_done, 0);
        check("bo_abort_retry", bus.mst_retry, 0);
        check("bo_abort_count_hold", bus.retry_count, 1);
        start_txn();
        check("bo_restart_busy", bus.mst_busy, 1);
        check("bo_restart_retry", bus.mst_retry, 0);
        check("bo_restart_count", bus.retry_count, 0);
`else
        // Without retry support the first TRY_AGAIN_LATER gives up.
        start_txn();
        tick();
        ack(TMN_TRY_AGAIN_LATER);
        check("noretry_giveup", bus.mst_giveup, 1);
        check("noretry_done", bus.mst_done, 1);
        check("noretry_count", bus.retry_count, 0);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.mst_retry) seen = 1'b1;
        end
        check("noretry_no_retry", seen, 0);

        // Abort while waiting for ACK, then restart.
        start_txn();
        tick();
        bus.mst_abort = 1'b1;
        tick();
        bus.mst_abort = 1'b0;
        check("wa_abort_busy", bus.mst_busy, 0);
        check("wa_abort_done", bus.mst_done, 0);
        start_txn();
        check("wa_restart_busy", bus.mst_busy, 1);
`endif

        // Asynchronous reset mid-transaction clears outputs without a clock edge.
        tick();
        #2;
        nub_reset = 1'b1;
        #1;
        check("async_rst_busy", bus.mst_busy, 0);
        check("async_rst_count", bus.retry_count, 0);
        tick();
        nub_reset = 1'b0;
        tick();
        check("post_rst_busy", bus.mst_busy, 0);
        check("post_rst_done", bus.mst_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
